// File: rtl/fir_rom_mac.sv
// fir_rom_mac: sequential-MAC FIR engine that reads its coefficients from an external ROM.
//   Accepts one signed sample per sample_valid/sample_ready handshake and shifts it into a
//   TAPS-deep delay line. It then walks ROM addresses 0..TAPS-1, one per clock, and
//   accumulates rom_q * x[k]. Each input sample produces one output, rounded half up and
//   saturated to OUT_W bits.
// Ports:
//   clock, reset_n          rising-edge clock, asynchronous active-low reset
//   sample_in/valid/ready   input sample handshake; ready is high only while IDLE
//   rom_address, rom_q      registered ROM address; data returns ROM_LATENCY edges later
//   out_data, out_valid     registered result, held between results; valid is a 1-cycle pulse
module fir_rom_mac #(
  parameter int DATA_W      = 16,
  parameter int COEF_W      = 16,
  parameter int TAPS        = 64,
  parameter int ADDR_W      = 7,
  parameter int ROM_LATENCY = 1,
  parameter int ACC_W       = 40,
  parameter int OUT_SHIFT   = 15,
  parameter int OUT_W       = 16
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic signed [DATA_W-1:0] sample_in,
  input  logic                     sample_valid,
  output logic                     sample_ready,
  output logic [ADDR_W-1:0]        rom_address,
  input  logic signed [COEF_W-1:0] rom_q,
  output logic signed [OUT_W-1:0]  out_data,
  output logic                     out_valid
);
  // Two spare bits keep the counter from wrapping before TAPS+ROM_LATENCY.
  localparam int CNT_W  = ADDR_W + 2;
  localparam int IDX_W  = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam int PROD_W = DATA_W + COEF_W;
  localparam logic [CNT_W-1:0] LAT      = CNT_W'(ROM_LATENCY);
  localparam logic [CNT_W-1:0] TAPS_C   = CNT_W'(TAPS);
  localparam logic [CNT_W-1:0] MAC_END  = CNT_W'(TAPS + ROM_LATENCY);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TAPS + ROM_LATENCY - 1);
  localparam logic signed [ACC_W:0] RND     = (ACC_W+1)'(1) <<< (OUT_SHIFT - 1);
  localparam logic signed [ACC_W:0] SAT_MAX = (ACC_W+1)'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [ACC_W:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                    r_state, w_state_nxt;
  logic signed [DATA_W-1:0]  r_x [TAPS];
  logic signed [ACC_W-1:0]   r_acc;
  logic [CNT_W-1:0]          r_cnt;
  logic [ADDR_W-1:0]         r_addr;
  logic signed [OUT_W-1:0]   r_out;
  logic                      r_out_valid;

  logic                      w_accept;
  logic                      w_mac_en;
  logic [CNT_W-1:0]          w_cnt_nxt;
  logic [IDX_W-1:0]          w_idx;
  logic signed [PROD_W-1:0]  w_prod;
  logic signed [ACC_W-1:0]   w_prod_ext;
  logic signed [ACC_W:0]     w_rnd;
  logic signed [ACC_W:0]     w_shift;
  logic signed [OUT_W-1:0]   w_sat;

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (sample_valid) w_state_nxt = S_RUN;
      S_RUN:   if (r_cnt == LAST_CNT) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output / control decode
  always_comb begin
    sample_ready = (r_state == S_IDLE);
    w_accept     = sample_ready & sample_valid;
    // rom_q for address k arrives when cnt == k + ROM_LATENCY.
    w_mac_en     = (r_state == S_RUN) && (r_cnt >= LAT) && (r_cnt < MAC_END);
  end

  assign w_cnt_nxt  = r_cnt + CNT_W'(1);
  assign w_idx      = IDX_W'(r_cnt - LAT);
  assign w_prod     = rom_q * r_x[w_idx];
  assign w_prod_ext = {{(ACC_W-PROD_W){w_prod[PROD_W-1]}}, w_prod};

  // Round half up, arithmetic shift, then clamp to the output range.
  assign w_rnd   = {r_acc[ACC_W-1], r_acc} + RND;
  assign w_shift = w_rnd >>> OUT_SHIFT;
  always_comb begin
    w_sat = w_shift[OUT_W-1:0];
    if (w_shift > SAT_MAX)      w_sat = SAT_MAX[OUT_W-1:0];
    else if (w_shift < SAT_MIN) w_sat = SAT_MIN[OUT_W-1:0];
  end

  // Datapath
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < TAPS; k++) r_x[k] <= '0;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_addr      <= '0;
      r_out       <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      case (r_state)
        S_IDLE: if (w_accept) begin
          for (int k = TAPS-1; k > 0; k--) r_x[k] <= r_x[k-1];
          r_x[0] <= sample_in;
          r_acc  <= '0;
          r_cnt  <= '0;
          r_addr <= '0;
        end
        S_RUN: begin
          r_cnt  <= w_cnt_nxt;
          // Address follows the counter but parks at 0 once all taps are issued.
          r_addr <= (w_cnt_nxt < TAPS_C) ? w_cnt_nxt[ADDR_W-1:0] : '0;
          if (w_mac_en) r_acc <= r_acc + w_prod_ext;
        end
        S_DONE: begin
          r_out       <= w_sat;
          r_out_valid <= 1'b1;
          r_addr      <= '0;
        end
        default: r_addr <= '0;
      endcase
    end
  end

  assign rom_address = r_addr;
  assign out_data    = r_out;
  assign out_valid   = r_out_valid;
endmodule
